// File: rtl/des_pkg.sv
// Shared DES P-box definitions: the P table, forward and inverse
// permutation functions and the per-transaction mode encoding.
// Words are indexed [32:1] so that DES bit n sits at index n.
package des_pkg;

    localparam int unsigned DATA_W = 32;
    // Index width covering 1..32 for the [32:1] ranges below.
    localparam int unsigned IDX_W  = 6;

    // DES P: output bit i takes input bit P_TABLE[i].
    localparam int unsigned P_TABLE [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    typedef enum logic {
        P_FWD = 1'b0,
        P_INV = 1'b1
    } p_mode_e;

    // Forward P: out[i] = in[P[i]].
    function automatic logic [DATA_W:1] p_fwd(input logic [DATA_W:1] d);
        logic [DATA_W:1] r;
        r = '0;
        for (int i = 1; i <= 32; i++) begin
            r[IDX_W'(i)] = d[IDX_W'(P_TABLE[IDX_W'(i)])];
        end
        return r;
    endfunction

    // Inverse P: out[P[i]] = in[i].
    function automatic logic [DATA_W:1] p_inv(input logic [DATA_W:1] d);
        logic [DATA_W:1] r;
        r = '0;
        for (int i = 1; i <= 32; i++) begin
            r[IDX_W'(P_TABLE[IDX_W'(i)])] = d[IDX_W'(i)];
        end
        return r;
    endfunction

    // Mode-selected permutation as applied in front of the first stage.
    function automatic logic [DATA_W:1] p_apply(input p_mode_e mode,
                                                 input logic [DATA_W:1] d);
        return (mode == P_INV) ? p_inv(d) : p_fwd(d);
    endfunction

endpackage

// File: rtl/des_pipe_stage.sv
// One valid/ready register slice carrying a 32-bit word, its tag and,
// when DES_P_PIPE_PARITY_EN is defined, the word's even-parity bit.
// The slice accepts whenever it is empty or its word is leaving, so a
// chain of slices never inserts bubbles and empty slices always fill.
module des_pipe_stage
    import des_pkg::*;
#(
    parameter int unsigned TAG_W = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready_c,
    input  logic [DATA_W:1]   up_data,
    input  logic [TAG_W-1:0]  up_tag,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W:1]   dn_data,
    output logic [TAG_W-1:0]  dn_tag
`ifdef DES_P_PIPE_PARITY_EN
    ,
    input  logic              up_par,
    output logic              dn_par
`endif
);

    // Slice can take a new word when empty or when its current word drains.
    assign up_ready_c = !dn_valid || dn_ready;

    // Valid/payload register; flush drops valid only, payload is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_tag   <= '0;
`ifdef DES_P_PIPE_PARITY_EN
            dn_par   <= 1'b0;
`endif
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
                dn_tag  <= up_tag;
`ifdef DES_P_PIPE_PARITY_EN
                dn_par  <= up_par;
`endif
            end
        end
    end

endmodule

// File: rtl/des_p_pipe.sv
// Pipelined DES P-box: applies P or P^-1 (chosen per word by in_mode)
// combinationally in front of a STAGES-deep valid/ready pipeline that
// carries the permuted word and an opaque tag with full backpressure.
// Optional feature macro: DES_P_PIPE_PARITY_EN adds in_par/out_par_err
// and carries an even-parity bit through every stage.
module des_p_pipe
    import des_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W:1]   in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:1]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
`ifdef DES_P_PIPE_PARITY_EN
    ,
    input  logic              in_par,
    output logic              out_par_err
`endif
);

    logic [DATA_W:1] perm_c;
    logic [STAGES:1] stage_valid;

    // Permutation ahead of stage 1; mode only matters on a transfer cycle.
    always_comb begin
        perm_c = p_apply(p_mode_e'(in_mode), in_data);
    end

    // Stage chain: stage k is fed by stage k-1 and backpressured by k+1.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic              up_valid;
        logic              up_ready_c;
        logic [DATA_W:1]   up_data;
        logic [TAG_W-1:0]  up_tag;
        logic              dn_valid;
        logic              dn_ready;
        logic [DATA_W:1]   dn_data;
        logic [TAG_W-1:0]  dn_tag;
`ifdef DES_P_PIPE_PARITY_EN
        logic              up_par;
        logic              dn_par;
`endif

        if (k == 1) begin : g_src
            assign up_valid = in_valid;
            assign up_data  = perm_c;
            assign up_tag   = in_tag;
`ifdef DES_P_PIPE_PARITY_EN
            // A permutation only reorders bits, so input parity still holds.
            assign up_par   = in_par;
`endif
        end else begin : g_link
            assign up_valid = g_stage[k-1].dn_valid;
            assign up_data  = g_stage[k-1].dn_data;
            assign up_tag   = g_stage[k-1].dn_tag;
`ifdef DES_P_PIPE_PARITY_EN
            assign up_par   = g_stage[k-1].dn_par;
`endif
        end

        if (k == STAGES) begin : g_sink
            assign dn_ready = out_ready;
        end else begin : g_fwd
            assign dn_ready = g_stage[k+1].up_ready_c;
        end

        des_pipe_stage #(
            .TAG_W (TAG_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_ready_c (up_ready_c),
            .up_data    (up_data),
            .up_tag     (up_tag),
            .dn_valid   (dn_valid),
            .dn_ready   (dn_ready),
            .dn_data    (dn_data),
            .dn_tag     (dn_tag)
`ifdef DES_P_PIPE_PARITY_EN
            ,
            .up_par     (up_par),
            .dn_par     (dn_par)
`endif
        );

        assign stage_valid[k] = dn_valid;
    end

    // Flush blocks acceptance so nothing enters while the pipe is cleared.
    assign in_ready = g_stage[1].up_ready_c && !flush;

    // Last stage drives the output handshake.
    assign out_valid = g_stage[STAGES].dn_valid;
    assign out_data  = g_stage[STAGES].dn_data;
    assign out_tag   = g_stage[STAGES].dn_tag;

    // Any occupied stage means work in flight.
    assign busy = |stage_valid;

`ifdef DES_P_PIPE_PARITY_EN
    // Recompute parity of the presented word and compare with the carried bit.
    assign out_par_err = out_valid && ((^out_data) != g_stage[STAGES].dn_par);
`endif

endmodule
